// File: rtl/pipeline_types_pkg.sv
// Shared types and constants for the instruction fetch stage.
package pipeline_types_pkg;

    // Canonical no-op (addi x0, x0, 0) placed in IF/ID when the entry is invalid.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        SQUASH,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_reg_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry holding register for an instruction that returned while decode
// was stalled. Drop has priority over load, load over release.
module fetch_hold_buffer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = pipeline_types_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_release,
    input  logic              i_drop,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;

    // Pend entry: capture on load, empty on release or drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_release) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/pipeline_fetch_stage.sv
// Instruction fetch stage: issues one imem read at a time for the current PC,
// loads the IF/ID register, stalls the PC register until an instruction is
// delivered or a redirect occurs, and discards fetches made stale by a flush.
module pipeline_fetch_stage #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = pipeline_types_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              id_stall,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [3:0]        imem_rmask,
    input  logic              imem_resp,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              fetch_stall,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr
);

    import pipeline_types_pkg::fetch_state_t;
    import pipeline_types_pkg::ISSUE;
    import pipeline_types_pkg::WAIT;
    import pipeline_types_pkg::SQUASH;
    import pipeline_types_pkg::HOLD;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_started;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_if_id_valid;
    logic [ADDR_W-1:0] r_if_id_pc;
    logic [DATA_W-1:0] r_if_id_instr;

    logic              w_out_free;
    logic              w_issue;
    logic              w_accept;
    logic              w_capture;
    logic              w_release;
    logic              w_drop;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_pc;
    logic [DATA_W-1:0] w_load_instr;
    logic              w_pend_valid;
    logic [ADDR_W-1:0] w_pend_pc;
    logic [DATA_W-1:0] w_pend_instr;

    assign w_out_free = ~r_if_id_valid | ~id_stall;

    // Next-state and per-cycle control decode; r_started blocks issue in the
    // first cycle after reset so that cycle always stalls the PC.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ISSUE: begin
                if (r_started && !flush && w_out_free) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp) begin
                    if (flush) begin
                        w_state_nxt = ISSUE;
                    end else if (w_out_free) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (flush) begin
                    w_state_nxt = SQUASH;
                end
            end
            SQUASH: begin
                if (imem_resp) begin
                    w_state_nxt = ISSUE;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ISSUE;
                end else if (!id_stall && w_pend_valid) begin
                    w_release   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            default: w_state_nxt = ISSUE;
        endcase
    end

    assign w_load       = w_accept | w_release;
    assign w_load_pc    = w_release ? w_pend_pc    : r_req_pc;
    assign w_load_instr = w_release ? w_pend_instr : imem_rdata;

    assign imem_rmask  = w_issue ? 4'hF : 4'h0;
    assign imem_addr   = w_issue ? pc : r_req_pc;
    assign fetch_stall = ~(r_started & (w_load | flush));

    // FSM state, post-reset marker and address of the outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ISSUE;
            r_started <= 1'b0;
            r_req_pc  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            if (w_issue) begin
                r_req_pc <= pc;
            end
        end
    end

    // IF/ID register: flush beats load, load beats consume; instr is kept at
    // NOP whenever the entry is invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
        end else if (flush) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
        end else if (w_load) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= w_load_pc;
            r_if_id_instr <= w_load_instr;
        end else if (!id_stall) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
        end
    end

    fetch_hold_buffer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_capture),
        .i_release (w_release),
        .i_drop    (w_drop),
        .i_pc      (r_req_pc),
        .i_instr   (imem_rdata),
        .o_valid   (w_pend_valid),
        .o_pc      (w_pend_pc),
        .o_instr   (w_pend_instr)
    );

    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;

endmodule
